pmod_als_spi_transmitter: RTL and testbench

PMOD_ALS_SPI_TRANSMITTER -- requirements
Module: pmod_als_spi_transmitter

---
 rtl/pmod_als_spi_transmitter.sv | 168 ++++++++++++++++
 tb/tb_pmod_als_spi_transmitter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pmod_als_spi_transmitter.sv
// SPI slave transmitter for an ambient-light sample: shifts {3'b000, sample, 5'b00000}
// MSB first on falling edges of an asynchronous master sck, framed by cs.
module pmod_als_spi_transmitter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cs,
    input  logic       sck,
    input  logic [7:0] sample,
    input  logic       sample_valid,
    output logic       sdo,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_abort
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic                   cs_prev_q;
    logic                   sck_prev_q;
    logic [SYNC_STAGES:0]   flush_q;
    logic                   armed_q;
    logic                   armed_d;

    state_t      state_q, state_d;
    logic [15:0] frame_q, frame_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic        sdo_q, sdo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;

    logic cs_s;
    logic sck_s;
    logic cs_fall_s;
    logic cs_rise_s;
    logic sck_fall_s;
    logic flushed_s;

    // Synchronizers for cs/sck plus the one-cycle-delayed copies used for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_q  <= {SYNC_STAGES{1'b1}};
            sck_sync_q <= {SYNC_STAGES{1'b1}};
            cs_prev_q  <= 1'b1;
            sck_prev_q <= 1'b1;
            flush_q    <= {(SYNC_STAGES+1){1'b0}};
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
            flush_q    <= {flush_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign cs_fall_s  = cs_prev_q & ~cs_s;
    assign cs_rise_s  = ~cs_prev_q & cs_s;
    assign sck_fall_s = sck_prev_q & ~sck_s;
    // The reset value of the synchronizer is not the pin level; only trust it once flushed.
    assign flushed_s  = flush_q[SYNC_STAGES];

    // Next-state, datapath and output decode.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        sdo_d     = sdo_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        armed_d   = armed_q | (flushed_s & cs_s & cs_prev_q);

        if (sample_valid) begin
            hold_d = sample;
        end else begin
            hold_d = hold_q;
        end

        case (state_q)
            ST_IDLE: begin
                sdo_d = 1'b0;
                if (armed_q && cs_fall_s) begin
                    state_d   = ST_SHIFT;
                    frame_d   = {3'b000, hold_q, 5'b00000};
                    bit_cnt_d = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                    sdo_d   = 1'b0;
                    abort_d = 1'b1;
                end else if (sck_fall_s) begin
                    sdo_d     = frame_q[15];
                    frame_d   = {frame_q[14:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        state_d = ST_TAIL;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_TAIL: begin
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                    sdo_d   = 1'b0;
                    done_d  = 1'b1;
                end else if (sck_fall_s) begin
                    sdo_d = 1'b0;
                end else begin
                    state_d = ST_TAIL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sdo_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            frame_q   <= 16'h0000;
            bit_cnt_q <= 4'd0;
            hold_q    <= 8'h00;
            sdo_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            hold_q    <= hold_d;
            sdo_q     <= sdo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            armed_q   <= armed_d;
        end
    end

    assign sdo         = sdo_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_pmod_als_spi_transmitter.sv
// Directed bench: drives an SPI master (16 clocks per sck period) and checks the shifted words and pulses.
module tb_pmod_als_spi_transmitter;

    logic       clock;
    logic       reset_n;
    logic       cs;
    logic       sck;
    logic [7:0] sample;
    logic       sample_valid;
    logic       sdo;
    logic       busy;
    logic       frame_done;
    logic       frame_abort;

    int tests;
    int fails;
    int done_total;
    int abort_total;

    pmod_als_spi_transmitter #(.SYNC_STAGES(2)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cs           (cs),
        .sck          (sck),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sdo          (sdo),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (frame_done === 1'b1) done_total++;
        if (frame_abort === 1'b1) abort_total++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge clock);
        sample       = v;
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
    endtask

    // One sck period; sdo is sampled 4 clocks after the fall (SYNC_STAGES+2).
    task automatic sck_cycle(output logic sdo_s, output logic busy_s);
        sck = 1'b0;
        repeat (4) @(negedge clock);
        sdo_s  = sdo;
        busy_s = busy;
        repeat (4) @(negedge clock);
        sck = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic run_frame(input int n_falls, input int load_at, input logic [7:0] load_val,
                             output logic [31:0] bits, output logic busy_ok);
        logic b;
        logic bz;
        bits    = 32'h0;
        busy_ok = 1'b1;
        cs      = 1'b0;
        repeat (8) @(negedge clock);
        for (int i = 0; i < n_falls; i++) begin
            if (i == load_at) load(load_val);
            sck_cycle(b, bz);
            bits    = {bits[30:0], b};
            busy_ok = busy_ok & bz;
        end
        cs = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    initial begin
        logic [31:0] bits;
        logic        bok;
        logic        b;
        logic        bz;
        logic        sdo_or;
        logic        busy_or;
        int          d0;
        int          a0;

        tests = 0; fails = 0; done_total = 0; abort_total = 0;
        reset_n = 1'b0; cs = 1'b1; sck = 1'b1; sample = 8'h00; sample_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_sdo", {31'b0, sdo}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, frame_done}, 32'h0);
        check("reset_abort", {31'b0, frame_abort}, 32'h0);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);

        // Basic frame with A5
        load(8'hA5);
        d0 = done_total; a0 = abort_total;
        run_frame(16, -1, 8'h00, bits, bok);
        check("a5_word", bits, 32'h0000_14A0);
        check("a5_busy", {31'b0, bok}, 32'h1);
        check("a5_done_cnt", done_total - d0, 32'h1);
        check("a5_abort_cnt", abort_total - a0, 32'h0);
        check("a5_sdo_after", {31'b0, sdo}, 32'h0);
        check("a5_busy_after", {31'b0, busy}, 32'h0);

        // Back-to-back frames, hold updated mid-frame
        load(8'h3C);
        d0 = done_total;
        run_frame(16, 5, 8'hFF, bits, bok);
        check("b2b_first", bits, 32'h0000_0780);
        run_frame(16, -1, 8'h00, bits, bok);
        check("b2b_second", bits, 32'h0000_1FE0);
        check("b2b_done_cnt", done_total - d0, 32'h2);

        // Abort after 7 falls
        d0 = done_total; a0 = abort_total;
        run_frame(7, -1, 8'h00, bits, bok);
        check("abort_bits", bits, 32'h0000_000F);
        check("abort_cnt", abort_total - a0, 32'h1);
        check("abort_done_cnt", done_total - d0, 32'h0);
        check("abort_sdo", {31'b0, sdo}, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'h0);

        // 20 falls with hold 81
        load(8'h81);
        d0 = done_total;
        run_frame(20, -1, 8'h00, bits, bok);
        check("tail_word16", {16'h0, bits[19:4]}, 32'h0000_1020);
        check("tail_extra", {28'h0, bits[3:0]}, 32'h0);
        check("tail_done_cnt", done_total - d0, 32'h1);

        // cs rise and sck fall together after 15 falls: cs wins, frame aborts
        load(8'hFF);
        d0 = done_total; a0 = abort_total;
        cs = 1'b0;
        repeat (8) @(negedge clock);
        for (int i = 0; i < 15; i++) sck_cycle(b, bz);
        cs = 1'b1; sck = 1'b0;
        repeat (8) @(negedge clock);
        sck = 1'b1;
        repeat (8) @(negedge clock);
        check("prio_abort_cnt", abort_total - a0, 32'h1);
        check("prio_done_cnt", done_total - d0, 32'h0);
        check("prio_busy", {31'b0, busy}, 32'h0);

        // Reset after 9 falls of an FF frame
        a0 = abort_total; d0 = done_total;
        cs = 1'b0;
        repeat (8) @(negedge clock);
        for (int i = 0; i < 9; i++) sck_cycle(b, bz);
        check("pre_reset_sdo", {31'b0, sdo}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("rst_sdo", {31'b0, sdo}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, frame_done}, 32'h0);
        check("rst_abort", {31'b0, frame_abort}, 32'h0);
        @(negedge clock);
        cs = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check("rst_no_abort", abort_total - a0, 32'h0);
        run_frame(16, -1, 8'h00, bits, bok);
        check("rst_cleared_word", bits, 32'h0);
        check("rst_done_cnt", done_total - d0, 32'h1);

        // cs low through reset release: no frame until cs toggles
        reset_n = 1'b0; cs = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        load(8'hA5);
        repeat (10) @(negedge clock);
        d0 = done_total; a0 = abort_total;
        sdo_or = 1'b0; busy_or = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sck_cycle(b, bz);
            sdo_or  = sdo_or | b;
            busy_or = busy_or | bz;
        end
        cs = 1'b1;
        repeat (8) @(negedge clock);
        check("lowcs_sdo", {31'b0, sdo_or}, 32'h0);
        check("lowcs_busy", {31'b0, busy_or}, 32'h0);
        check("lowcs_pulses", (done_total - d0) + (abort_total - a0), 32'h0);
        run_frame(16, -1, 8'h00, bits, bok);
        check("lowcs_next_word", bits, 32'h0000_14A0);
        check("lowcs_done_cnt", done_total - d0, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
